voice_fetch_scheduler: RTL and testbench

//  Per-sample SRAM fetch sequencer for the multi-voice note datapath. On each audio sample tick it

---
 rtl/voice_fetch_scheduler_if.sv | 28 ++
 rtl/voice_fetch_scheduler.sv | 144 ++++++++++++++
 tb/tb_voice_fetch_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/voice_fetch_scheduler_if.sv
// Fetch-sequencer bus: sample tick/voice flags in, SRAM/MAR/MDR control strobes and status out.
// The scheduler uses the master modport; the datapath/codec side uses slave.
interface voice_fetch_scheduler_if #(
  parameter int unsigned NUM_VOICES = 4
);
  localparam int unsigned SEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                  sample_clk;
  logic [NUM_VOICES-1:0] voice_active;
  logic                  ovr_clr;
  logic                  MAR_LD;
  logic [SEL_W-1:0]      select;
  logic                  OE;
  logic [NUM_VOICES-1:0] MDR_LD;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;

  modport master (
    input  sample_clk, voice_active, ovr_clr,
    output MAR_LD, select, OE, MDR_LD, busy, frame_done, overrun
  );

  modport slave (
    output sample_clk, voice_active, ovr_clr,
    input  MAR_LD, select, OE, MDR_LD, busy, frame_done, overrun
  );
endinterface

// File: rtl/voice_fetch_scheduler.sv
// Per-sample SRAM fetch sequencer: one ADDR/READ.../LATCH pass per voice on each sample tick.
// Optional IDLE_SKIP_EN skips voices whose voice_active bit was clear at the tick.
module voice_fetch_scheduler #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                     Clk,
  input logic                     Reset,
  voice_fetch_scheduler_if.master bus
);
  localparam int unsigned SEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned WC_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StAddr, StRead, StLatch, StDone} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] v_q, v_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic [2:0]       sync_q;
  logic             overrun_q, overrun_d;
  logic             tick;
  logic             first_vld, next_vld;
  logic [SEL_W-1:0] first_v, next_v;

  // Rising edge of the synchronised sample clock
  assign tick = sync_q[1] & ~sync_q[2];

`ifdef IDLE_SKIP_EN
  logic [NUM_VOICES-1:0] mask_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mask_q <= '0;
    end else if (state_q == StIdle && tick) begin
      mask_q <= bus.voice_active;
    end
  end

  // Descending scan leaves the lowest qualifying index
  always_comb begin
    first_vld = 1'b0;
    first_v   = '0;
    next_vld  = 1'b0;
    next_v    = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (bus.voice_active[i]) begin
        first_vld = 1'b1;
        first_v   = SEL_W'(i);
      end
      if (mask_q[i] && (i > int'(v_q))) begin
        next_vld = 1'b1;
        next_v   = SEL_W'(i);
      end
    end
  end
`else
  logic unused_voice_active;
  assign unused_voice_active = ^bus.voice_active;
  assign first_vld = 1'b1;
  assign first_v   = '0;
  assign next_vld  = (int'(v_q) < int'(NUM_VOICES) - 1);
  assign next_v    = v_q + SEL_W'(1);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      v_q       <= '0;
      wait_q    <= '0;
      sync_q    <= 3'b111;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      wait_q    <= wait_d;
      sync_q    <= {sync_q[1:0], bus.sample_clk};
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          if (first_vld) begin
            state_d = StAddr;
            v_d     = first_v;
          end else begin
            state_d = StDone;
          end
        end
      end
      StAddr: begin
        state_d = StRead;
        wait_d  = '0;
      end
      StRead: begin
        if (wait_q == WC_W'(WAIT_CYCLES - 1)) begin
          state_d = StLatch;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      StLatch: begin
        if (next_vld) begin
          state_d = StAddr;
          v_d     = next_v;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A set in the same cycle as a clear wins
    overrun_d = (overrun_q & ~bus.ovr_clr) | (tick & (state_q != StIdle));
  end

  always_comb begin
    bus.MAR_LD     = 1'b0;
    bus.OE         = 1'b1;
    bus.MDR_LD     = '0;
    bus.frame_done = 1'b0;
    unique case (state_q)
      StAddr: bus.MAR_LD = 1'b1;
      StRead: bus.OE = 1'b0;
      StLatch: begin
        bus.OE = 1'b0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
          bus.MDR_LD[i] = (v_q == SEL_W'(i));
        end
      end
      StDone:  bus.frame_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.select  = v_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_voice_fetch_scheduler.sv
// Directed bench: a 4-voice/2-wait scheduler and a 1-voice/1-wait scheduler, checked cycle by cycle.
module tb_voice_fetch_scheduler;
  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 Clk = ~Clk;

  voice_fetch_scheduler_if #(.NUM_VOICES(4)) ifa ();
  voice_fetch_scheduler_if #(.NUM_VOICES(1)) ifb ();

  voice_fetch_scheduler #(.NUM_VOICES(4), .WAIT_CYCLES(2)) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifa)
  );

  voice_fetch_scheduler #(.NUM_VOICES(1), .WAIT_CYCLES(1)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifb)
  );

  function automatic logic [10:0] sample_a();
    return {ifa.MAR_LD, ifa.select, ifa.OE, ifa.MDR_LD, ifa.busy, ifa.frame_done, ifa.overrun};
  endfunction

  // {MAR_LD, select, OE, MDR_LD, busy, frame_done} at frame cycle c for 4 voices, 2 wait cycles
  function automatic logic [9:0] exp_frame(input int c);
    int v, p;
    if (c < 16) begin
      v = c / 4;
      p = c % 4;
      return {p == 0, 2'(v), p == 0, (p == 3) ? 4'(1 << v) : 4'b0000, 1'b1, 1'b0};
    end
    if (c == 16) return {1'b0, 2'd3, 1'b1, 4'b0000, 1'b1, 1'b1};
    return {1'b0, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b0};
  endfunction

  // Raise sample_clk just after an edge; returns at the negedge inside frame cycle 0
  task automatic align_a();
    @(posedge Clk);
    #1 ifa.sample_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic frame_run(input string name, input int n, input bit hold, input int retick_at,
                           input int clr_at, input int ovr_from);
    logic [10:0] got, want;
    align_a();
    for (int c = 0; c < n; c++) begin
      got  = sample_a();
      want = {exp_frame(c), (ovr_from >= 0) && (c >= ovr_from)};
      n_checks++;
      if (got !== want) $display("FAIL %s cycle %0d: got %b, want %b", name, c, got, want);
      else n_pass++;
      if (!hold && c == 1) ifa.sample_clk = 1'b0;
      if (c == retick_at) ifa.sample_clk = 1'b1;
      if (retick_at >= 0 && c == retick_at + 2) ifa.sample_clk = 1'b0;
      ifa.ovr_clr = (c == clr_at);
      @(negedge Clk);
    end
    ifa.ovr_clr = 1'b0;
    if (!hold) ifa.sample_clk = 1'b0;
  endtask

  task automatic test_reset();
    logic active;
    Reset = 1'b1;
    ifa.sample_clk = 1'b1;
    ifa.voice_active = 4'hF;
    ifa.ovr_clr = 1'b0;
    ifb.sample_clk = 1'b0;
    ifb.voice_active = 1'b1;
    ifb.ovr_clr = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_checks++;
    if (sample_a() !== 11'b000_1_0000_000)
      $display("FAIL reset_a: got %b, want %b", sample_a(), 11'b000_1_0000_000);
    else n_pass++;
    n_checks++;
    if ({ifb.MAR_LD, ifb.OE, ifb.MDR_LD, ifb.busy, ifb.frame_done, ifb.overrun} !== 6'b010000)
      $display("FAIL reset_b: got %b, want 010000",
               {ifb.MAR_LD, ifb.OE, ifb.MDR_LD, ifb.busy, ifb.frame_done, ifb.overrun});
    else n_pass++;
    Reset = 1'b0;
    active = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (ifa.busy || ifa.frame_done) active = 1'b1;
    end
    n_checks++;
    if (active !== 1'b0) $display("FAIL reset_high_sample_clk: got frame activity %b, want 0", active);
    else n_pass++;
    ifa.sample_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_frame();
    frame_run("frame", 20, 1'b0, -1, -1, -1);
  endtask

  task automatic test_overrun();
    frame_run("overrun", 24, 1'b0, 3, -1, 6);
    n_checks++;
    if (ifa.overrun !== 1'b1) $display("FAIL overrun_sticky: got %b, want 1", ifa.overrun);
    else n_pass++;
    ifa.ovr_clr = 1'b1;
    @(negedge Clk);
    ifa.ovr_clr = 1'b0;
    n_checks++;
    if (ifa.overrun !== 1'b0) $display("FAIL ovr_clr: got %b, want 0", ifa.overrun);
    else n_pass++;
    frame_run("overrun_with_clr", 20, 1'b0, 3, 5, 6);
    ifa.ovr_clr = 1'b1;
    @(negedge Clk);
    ifa.ovr_clr = 1'b0;
    n_checks++;
    if (ifa.overrun !== 1'b0) $display("FAIL ovr_clr_again: got %b, want 0", ifa.overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic active;
    frame_run("pre_reset", 6, 1'b1, -1, -1, -1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    n_checks++;
    if ({ifa.MAR_LD, ifa.OE, ifa.MDR_LD, ifa.busy, ifa.frame_done} !== 8'b0_1_0000_00)
      $display("FAIL reset_mid_frame: got %b, want 01000000",
               {ifa.MAR_LD, ifa.OE, ifa.MDR_LD, ifa.busy, ifa.frame_done});
    else n_pass++;
    active = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      if (ifa.busy || ifa.frame_done || ifa.MDR_LD != 4'b0000) active = 1'b1;
    end
    n_checks++;
    if (active !== 1'b0) $display("FAIL post_reset_quiet: got activity %b, want 0", active);
    else n_pass++;
    ifa.sample_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

`ifdef IDLE_SKIP_EN
  task automatic test_idle_skip();
    logic [8:0] got, want;
    ifa.voice_active = 4'b0101;
    align_a();
    for (int c = 0; c < 12; c++) begin
      got  = {ifa.MAR_LD, ifa.select, ifa.OE, ifa.MDR_LD, ifa.frame_done};
      want = {c == 0 || c == 4, (c < 4) ? 2'd0 : 2'd2, !((c >= 1 && c <= 3) || (c >= 5 && c <= 7)),
              (c == 3) ? 4'b0001 : (c == 7) ? 4'b0100 : 4'b0000, c == 8};
      n_checks++;
      if (got !== want) $display("FAIL skip_0101 cycle %0d: got %b, want %b", c, got, want);
      else n_pass++;
      if (c == 1) ifa.sample_clk = 1'b0;
      @(negedge Clk);
    end
    ifa.voice_active = 4'b0000;
    align_a();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({ifa.MAR_LD, ifa.OE, ifa.MDR_LD, ifa.frame_done} !== {1'b0, 1'b1, 4'b0000, c == 0})
        $display("FAIL skip_all cycle %0d: got %b", c,
                 {ifa.MAR_LD, ifa.OE, ifa.MDR_LD, ifa.frame_done});
      else n_pass++;
      if (c == 1) ifa.sample_clk = 1'b0;
      @(negedge Clk);
    end
    ifa.voice_active = 4'hF;
  endtask
`else
  task automatic test_voice_active_ignored();
    ifa.voice_active = 4'b0000;
    frame_run("voice_active_ignored", 20, 1'b0, -1, -1, -1);
    ifa.voice_active = 4'hF;
  endtask
`endif

  task automatic test_back_to_back();
    logic [5:0] got, want;
    int p;
    @(posedge Clk);
    #1 ifb.sample_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    for (int c = 0; c < 16; c++) begin
      p    = c % 8;
      got  = {ifb.MAR_LD, ifb.OE, ifb.MDR_LD, ifb.busy, ifb.frame_done, ifb.overrun};
      want = {p == 0, !(p == 1 || p == 2), p == 2, p <= 3, p == 3, 1'b0};
      n_checks++;
      if (got !== want) $display("FAIL one_voice cycle %0d: got %b, want %b", c, got, want);
      else n_pass++;
      if (c == 1 || c == 7) ifb.sample_clk = 1'b0;
      if (c == 5) ifb.sample_clk = 1'b1;
      @(negedge Clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_reset_mid_frame();
`ifdef IDLE_SKIP_EN
    test_idle_skip();
`else
    test_voice_active_ignored();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
